osc_voice_scheduler: RTL and testbench
======================================

Name: osc_voice_scheduler

Overview:
Time-multiplexed phase-accumulator engine and scheduler for the sawtooth oscillator datapath. One accumulator is shared across NUM_VOICES voices, and per-voice phase, increment and gate live in a small register file. On each sample tick the block sweeps every voice once and emits one signed sawtooth sample per voice as a tagged stream. It sits between the note/config front end and the per-voice mixer/envelope stage.

Parameters:
NUM_VOICES, 8, number of voices swept per sample tick (>=2).
PHASE_W, 32, phase accumulator and amplitude width.
IDX_W, $clog2(NUM_VOICES), voice index width (derived, not overridden).

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset; asynchronous, active-low
sample_tick_in  input  1  single-cycle pulse at audio sample rate; starts a sweep
cfg_valid_in  input  1  config write request
cfg_ready_out  output  1  config write accepted when valid&ready
cfg_voice_in  input  IDX_W  target voice
cfg_gate_in  input  1  voice enable (note on=1/off=0)
cfg_incr_in  input  PHASE_W  phase increment (frequency word)
cfg_reset_phase_in  input  1  also clear target voice phase to 0
amp_valid_out  output  1  amp_out/amp_voice_out valid this cycle
amp_voice_out  output  IDX_W  voice index of current sample
amp_out  output  PHASE_W signed  sawtooth sample
amp_gate_out  output  1  gate of current voice
frame_done_out  output  1  pulse with the last voice's sample
busy_out  output  1  sweep in progress
overrun_out  output  1  sticky: tick arrived while busy

Behaviour:
- Reset (async assert, sync deassert by the top level): state IDLE; all phases, incrs and gates = 0; all outputs 0 except cfg_ready_out = 1. Assert mid-sweep: the sweep aborts immediately and outputs drop to 0 in the same cycle.
- FSM has two states, IDLE and SWEEP.
- IDLE -> SWEEP on sample_tick_in; idx <= 0. SWEEP increments idx each cycle. After idx = NUM_VOICES-1 is processed, the FSM returns to IDLE.
- Processing voice i in a SWEEP cycle:
  - Registered outputs on the next edge: amp_valid_out = 1, amp_voice_out = i, amp_gate_out = gate[i].
  - amp_out = gate[i] ? signed(phase[i] ^ (1<<(PHASE_W-1))) : 0. This is the pre-increment phase.
  - If gate[i], phase[i] <= phase[i] + incr[i], mod 2^PHASE_W with silent wrap. Otherwise the phase holds.
- Latency: tick sampled at edge k. Voice v sample is valid during the cycle after edge k+1+v. amp_valid_out is high for exactly NUM_VOICES consecutive cycles per tick.
- frame_done_out is high only with the voice NUM_VOICES-1 sample.
- busy_out = (state == SWEEP). The minimum accepted tick spacing is NUM_VOICES+1 cycles.
- Tick while busy_out = 1: ignored (no restart, no extra samples); overrun_out <= 1. It is sticky until reset.
- cfg_ready_out = !busy_out.
  - On accept: gate[v] <= cfg_gate_in and incr[v] <= cfg_incr_in.
  - If cfg_reset_phase_in, phase[v] <= 0; otherwise the phase is preserved, for glide without click.
- cfg_valid_in held during a sweep stalls until the first IDLE cycle. The requester must hold its fields stable.
- cfg_voice_in >= NUM_VOICES: handshake completes, write dropped.
- Tick and cfg accepted on the same edge: the config write takes effect at that edge. Voice processing in the sweep sees the new values.
- Gate off then on without reset_phase: resumes from the held phase.

Decomposition:
- Package osc_pkg holds:
  - sched_state_t enum {IDLE, SWEEP}
  - PHASE_W default and SAW_MSB_MASK constant
  - voice_cfg_t struct {gate, incr}
- One sub-module, osc_voice_regfile. It holds the gate/incr/phase arrays with:
  - one combinational read port (idx)
  - one phase write-back port
  - one cfg write port
- Phase write-back and cfg write never collide, because cfg only writes in IDLE.

Test Plan:
(NUM_VOICES=4, PHASE_W=32)
1. Hold rst_n_in low, then release -> all outputs 0, cfg_ready_out = 1, busy_out = 0. A tick gives 4 valids, all with amp_out = 0 and amp_gate_out = 0.
2. cfg voice1 gate=1, incr=0x4000_0000, reset_phase=1; 5 ticks spaced 10 cycles -> voice1 amp_out = 0x8000_0000, 0xC000_0000, 0x0000_0000, 0x4000_0000, 0x8000_0000 (wrap). Voices 0/2/3 give 0. frame_done_out accompanies voice3 each time.
3. Tick, then a second tick 2 cycles later -> exactly 4 valids, overrun_out = 1 and stays 1. busy_out spans 4 cycles.
4. cfg_valid_in on voice0 (incr=1, reset_phase=1) raised in the same cycle as a tick from IDLE -> accepted that edge. Voice0 first sample = 0x8000_0000; next sweep gives 0x8000_0001.
5. cfg_valid_in raised mid-sweep -> cfg_ready_out = 0 until IDLE, then accepted exactly once. Voice2 (cfg_voice_in=2) is updated only after frame_done_out.
6. rst_n_in pulsed low while voice2 is being output -> amp_valid_out falls the same cycle, with no frame_done_out. A later tick yields all-zero samples (gates cleared).

Source files
------------

// File: rtl/osc_pkg.sv
// osc_pkg: shared types and constants for the sawtooth voice scheduler.
package osc_pkg;
  typedef enum logic {IDLE, SWEEP} sched_state_t;
  localparam int DEF_PHASE_W = 32;
  localparam logic [DEF_PHASE_W-1:0] SAW_MSB_MASK = 32'h8000_0000;
  typedef struct packed {
    logic                   gate;
    logic [DEF_PHASE_W-1:0] incr;
  } voice_cfg_t;
endpackage

// File: rtl/osc_voice_regfile.sv
// osc_voice_regfile: per-voice gate/incr/phase storage with one read, one write-back and one cfg port.
module osc_voice_regfile
  import osc_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  parameter  int PHASE_W    = DEF_PHASE_W,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [IDX_W-1:0]   rd_idx_in,
  output voice_cfg_t         rd_cfg_out,
  output logic [PHASE_W-1:0] rd_phase_out,
  input  logic               wb_en_in,
  input  logic [IDX_W-1:0]   wb_idx_in,
  input  logic [PHASE_W-1:0] wb_phase_in,
  input  logic               cfg_en_in,
  input  logic [IDX_W-1:0]   cfg_idx_in,
  input  voice_cfg_t         cfg_data_in,
  input  logic               cfg_reset_phase_in
);
  voice_cfg_t         r_cfg   [NUM_VOICES];
  logic [PHASE_W-1:0] r_phase [NUM_VOICES];
  logic               w_cfg_hit;

  assign rd_cfg_out   = r_cfg[rd_idx_in];
  assign rd_phase_out = r_phase[rd_idx_in];
  // out-of-range voices complete the handshake but store nothing
  assign w_cfg_hit    = cfg_en_in && (int'(cfg_idx_in) < NUM_VOICES);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_cfg[i]   <= '0;
        r_phase[i] <= '0;
      end
    end else begin
      if (wb_en_in) r_phase[wb_idx_in] <= wb_phase_in;
      if (w_cfg_hit) begin
        r_cfg[cfg_idx_in] <= cfg_data_in;
        if (cfg_reset_phase_in) r_phase[cfg_idx_in] <= '0;
      end
    end
  end
endmodule

// File: rtl/osc_voice_scheduler.sv
// osc_voice_scheduler: sweeps all voices through one shared phase accumulator per sample tick,
// emitting a tagged signed sawtooth sample per voice.
module osc_voice_scheduler
  import osc_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  parameter  int PHASE_W    = DEF_PHASE_W,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      sample_tick_in,
  input  logic                      cfg_valid_in,
  output logic                      cfg_ready_out,
  input  logic [IDX_W-1:0]          cfg_voice_in,
  input  logic                      cfg_gate_in,
  input  logic [PHASE_W-1:0]        cfg_incr_in,
  input  logic                      cfg_reset_phase_in,
  output logic                      amp_valid_out,
  output logic [IDX_W-1:0]          amp_voice_out,
  output logic signed [PHASE_W-1:0] amp_out,
  output logic                      amp_gate_out,
  output logic                      frame_done_out,
  output logic                      busy_out,
  output logic                      overrun_out
);
  sched_state_t              r_state;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_amp_valid, r_amp_gate, r_frame_done, r_overrun;
  logic [IDX_W-1:0]          r_amp_voice;
  logic signed [PHASE_W-1:0] r_amp;
  voice_cfg_t                w_cfg;
  logic [PHASE_W-1:0]        w_phase, w_saw;
  logic                      w_sweep, w_last, w_gated;

  assign w_sweep = (r_state == SWEEP);
  assign w_last  = (r_idx == IDX_W'(NUM_VOICES - 1));
  assign w_gated = w_sweep & w_cfg.gate;
  // flipping the MSB maps the unsigned phase ramp onto a zero-centred signed saw
  assign w_saw   = {~w_phase[PHASE_W-1], w_phase[PHASE_W-2:0]};

  osc_voice_regfile #(.NUM_VOICES(NUM_VOICES), .PHASE_W(PHASE_W)) u_regfile (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .rd_idx_in          (r_idx),
    .rd_cfg_out         (w_cfg),
    .rd_phase_out       (w_phase),
    .wb_en_in           (w_gated),
    .wb_idx_in          (r_idx),
    .wb_phase_in        (w_phase + PHASE_W'(w_cfg.incr)),
    .cfg_en_in          (cfg_valid_in & ~w_sweep),
    .cfg_idx_in         (cfg_voice_in),
    .cfg_data_in        ('{gate: cfg_gate_in, incr: DEF_PHASE_W'(cfg_incr_in)}),
    .cfg_reset_phase_in (cfg_reset_phase_in)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_amp_valid  <= 1'b0;
      r_amp_voice  <= '0;
      r_amp        <= '0;
      r_amp_gate   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_amp_valid  <= w_sweep;
      r_amp_voice  <= w_sweep ? r_idx : '0;
      r_amp        <= w_gated ? w_saw : '0;
      r_amp_gate   <= w_gated;
      r_frame_done <= w_sweep & w_last;
      r_overrun    <= r_overrun | (w_sweep & sample_tick_in);
      if (!w_sweep) begin
        r_state <= sample_tick_in ? SWEEP : IDLE;
        r_idx   <= '0;
      end else begin
        r_state <= w_last ? IDLE : SWEEP;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  assign cfg_ready_out  = ~w_sweep;
  assign busy_out       = w_sweep;
  assign amp_valid_out  = r_amp_valid;
  assign amp_voice_out  = r_amp_voice;
  assign amp_out        = r_amp;
  assign amp_gate_out   = r_amp_gate;
  assign frame_done_out = r_frame_done;
  assign overrun_out    = r_overrun;
endmodule

// File: tb/tb_osc_voice_scheduler.sv
// tb_osc_voice_scheduler: directed scoreboard bench for the 4-voice scheduler.
module tb_osc_voice_scheduler;
  logic        clk_in = 1'b0, rst_n_in = 1'b0, sample_tick_in = 1'b0;
  logic        cfg_valid_in = 1'b0, cfg_gate_in = 1'b0, cfg_reset_phase_in = 1'b0;
  logic [1:0]  cfg_voice_in = '0;
  logic [31:0] cfg_incr_in = '0;
  logic        cfg_ready_out, amp_valid_out, amp_gate_out, frame_done_out, busy_out, overrun_out;
  logic [1:0]  amp_voice_out;
  logic signed [31:0] amp_out;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a;
    logic        g;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0, busy_cnt = 0, acc_cnt = 0;

  osc_voice_scheduler #(.NUM_VOICES(4), .PHASE_W(32)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .sample_tick_in     (sample_tick_in),
    .cfg_valid_in       (cfg_valid_in),
    .cfg_ready_out      (cfg_ready_out),
    .cfg_voice_in       (cfg_voice_in),
    .cfg_gate_in        (cfg_gate_in),
    .cfg_incr_in        (cfg_incr_in),
    .cfg_reset_phase_in (cfg_reset_phase_in),
    .amp_valid_out      (amp_valid_out),
    .amp_voice_out      (amp_voice_out),
    .amp_out            (amp_out),
    .amp_gate_out       (amp_gate_out),
    .frame_done_out     (frame_done_out),
    .busy_out           (busy_out),
    .overrun_out        (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every presented sample is matched against the oldest expectation
  always @(negedge clk_in) begin
    chk("frame_done_without_valid", 64'(frame_done_out & ~amp_valid_out), 0);
    if (amp_valid_out) begin
      if (exp_q.size() == 0) chk("unexpected_sample_voice", 64'(amp_voice_out), 64'hFF);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("amp_voice", 64'(amp_voice_out), 64'(e.v));
        chk("amp_out", 64'(unsigned'(amp_out)), 64'(e.a));
        chk("amp_gate", 64'(amp_gate_out), 64'(e.g));
        chk("frame_done", 64'(frame_done_out), 64'(e.fd));
      end
    end
  end

  always @(negedge clk_in) if (busy_out) busy_cnt++;
  always @(posedge clk_in) if (cfg_valid_in && cfg_ready_out) acc_cnt++;

  task automatic push_frame(input logic [31:0] a0, a1, a2, a3, input logic [3:0] g, input int n);
    logic [31:0] a[4];
    a = '{a0, a1, a2, a3};
    for (int v = 0; v < n; v++) exp_q.push_back('{v: 2'(v), a: a[v], g: g[v], fd: (v == 3)});
  endtask

  task automatic tick();
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("idle_timeout", 64'(busy_out), 0);
  endtask

  task automatic gap();
    repeat (4) @(negedge clk_in);
  endtask

  task automatic set_cfg(input logic [1:0] v, input logic g, input logic [31:0] inc, input logic rp);
    cfg_voice_in = v;
    cfg_gate_in = g;
    cfg_incr_in = inc;
    cfg_reset_phase_in = rp;
    cfg_valid_in = 1'b1;
  endtask

  logic [31:0] saw1 [5] = '{32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000};

  initial begin
    int n;
    // 1: reset state, then an all-silent sweep
    repeat (3) @(negedge clk_in);
    chk("rst_valid", 64'(amp_valid_out), 0);
    chk("rst_amp", 64'(unsigned'(amp_out)), 0);
    chk("rst_ready", 64'(cfg_ready_out), 1);
    chk("rst_busy", 64'(busy_out), 0);
    chk("rst_overrun", 64'(overrun_out), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("post_rst_ready", 64'(cfg_ready_out), 1);
    chk("post_rst_voice", 64'(amp_voice_out), 0);
    push_frame(0, 0, 0, 0, 4'b0000, 4);
    tick();
    wait_idle();
    gap();
    // 2: voice1 quarter-cycle increments across 5 ticks, including wrap
    set_cfg(2'd1, 1'b1, 32'h4000_0000, 1'b1);
    @(negedge clk_in);
    cfg_valid_in = 1'b0;
    for (int t = 0; t < 5; t++) begin
      push_frame(0, saw1[t], 0, 0, 4'b0010, 4);
      tick();
      repeat (9) @(negedge clk_in);
    end
    chk("no_overrun_yet", 64'(overrun_out), 0);
    // 3: tick while busy is ignored and sets sticky overrun
    busy_cnt = 0;
    push_frame(0, 32'hC000_0000, 0, 0, 4'b0010, 4);
    tick();
    @(negedge clk_in);
    tick();
    wait_idle();
    gap();
    chk("busy_span", 64'(busy_cnt), 4);
    chk("overrun_set", 64'(overrun_out), 1);
    repeat (5) @(negedge clk_in);
    chk("overrun_sticky", 64'(overrun_out), 1);
    // 4: cfg and tick on the same edge; sweep sees the new config
    push_frame(32'h8000_0000, 32'h0000_0000, 0, 0, 4'b0011, 4);
    set_cfg(2'd0, 1'b1, 32'h1, 1'b1);
    sample_tick_in = 1'b1;
    chk("ready_with_tick", 64'(cfg_ready_out), 1);
    @(negedge clk_in);
    cfg_valid_in = 1'b0;
    sample_tick_in = 1'b0;
    wait_idle();
    gap();
    push_frame(32'h8000_0001, 32'h4000_0000, 0, 0, 4'b0011, 4);
    tick();
    wait_idle();
    gap();
    // 5: cfg raised mid-sweep stalls until idle, accepted once
    push_frame(32'h8000_0002, 32'h8000_0000, 0, 0, 4'b0011, 4);
    acc_cnt = 0;
    tick();
    set_cfg(2'd2, 1'b1, 32'h1000_0000, 1'b1);
    chk("ready_low_mid_sweep", 64'(cfg_ready_out), 0);
    n = 0;
    while (!cfg_ready_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("ready_after_sweep", 64'(cfg_ready_out), 1);
    @(negedge clk_in);
    cfg_valid_in = 1'b0;
    gap();
    chk("cfg_accept_once", 64'(acc_cnt), 1);
    push_frame(32'h8000_0003, 32'hC000_0000, 32'h8000_0000, 0, 4'b0111, 4);
    tick();
    wait_idle();
    gap();
    // 6: async reset while voice2 is presented
    push_frame(32'h8000_0004, 32'h0000_0000, 32'h9000_0000, 0, 4'b0111, 3);
    tick();
    repeat (3) @(negedge clk_in);
    #1 rst_n_in = 1'b0;
    #1;
    chk("abort_valid", 64'(amp_valid_out), 0);
    chk("abort_frame_done", 64'(frame_done_out), 0);
    chk("abort_busy", 64'(busy_out), 0);
    chk("abort_overrun_cleared", 64'(overrun_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    gap();
    chk("abort_queue_drained", 64'(exp_q.size()), 0);
    push_frame(0, 0, 0, 0, 4'b0000, 4);
    tick();
    wait_idle();
    gap();
    chk("final_queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
